dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the RV32i CPU load/store path and a host/loader port.
//  Used by the debug loader and result readback.
//  Per-cycle arbiter: CPU has fixed priority; a streak counter bounds host starvation.
//  The RAM is synchronous, with 1-cycle read latency. Responses are routed back to the owner one cycle after grant.
//  Sits between RV32iPCPU (ALU_out/data_out/mem_w) and the data RAM instance.
// PARAMETERS
//  ADDR_W      14  word-address width (byte addr[15:2])
//  DATA_W      32  data width
//  MAX_STREAK  4   max consecutive CPU grants while host_req is high; next conflict goes to host
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       asynchronous reset, active-low
//  cpu_req     in   1       CPU access request (load or store)
//  cpu_we      in   1       1=store, 0=load
//  cpu_addr    in   ADDR_W  CPU word address
//  cpu_wdata   in   DATA_W  CPU store data
//  cpu_gnt     out  1       CPU granted this cycle (comb)
//  cpu_stall   out  1       cpu_req & ~cpu_gnt (comb); freezes the pipeline
//  cpu_rvalid  out  1       CPU response valid (cycle after grant)
//  cpu_rdata   out  DATA_W  CPU load data, valid with cpu_rvalid
//  host_req    in   1       host request; held with addr/we/wdata stable until host_gnt
//  host_we     in   1       1=write, 0=read
//  host_addr   in   ADDR_W  host word address
//  host_wdata  in   DATA_W  host write data
//  host_gnt    out  1       host granted this cycle (comb, 1-cycle pulse per access)
//  host_ack    out  1       host response valid (cycle after grant)
//  host_rdata  out  DATA_W  host read data, valid with host_ack
//  mem_en      out  1       RAM enable (= cpu_gnt | host_gnt)
//  mem_we      out  1       RAM write enable
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  DATA_W  RAM write data
//  mem_rdata   in   DATA_W  RAM read data, 1 cycle after mem_en
// BEHAVIOUR
//  - Grant, same cycle, comb:
//      host_gnt = host_req & (~cpu_req | streak==MAX_STREAK);
//      cpu_gnt  = cpu_req & ~host_gnt.
//    At most one grant per cycle. Back-to-back grants every cycle are allowed (fully pipelined).
//  - Mem mux: drives the granted requester's addr/we/wdata. When idle: mem_en=0, mem_we=0, addr/wdata=0.
//  - streak register (clog2(MAX_STREAK+1) bits):
//      +1 on a cpu_gnt with host_req=1;
//      cleared on host_gnt or when host_req=0;
//      never exceeds MAX_STREAK.
//  - Response register, set at the posedge after a grant:
//      owner = 2'b01 (CPU) / 2'b10 (host) / 2'b00 (none).
//    Next cycle: cpu_rvalid = owner[0], host_ack = owner[1].
//    cpu_rdata/host_rdata = mem_rdata when the respective valid is high, else 0. Writes also ack.
//  - Read-after-write to the same address on consecutive grants: the RAM returns the new data (write-first RAM). The arbiter adds no forwarding.
//  - Reset (rst=0, any time):
//      streak=0, owner=0;
//      cpu_rvalid, host_ack, cpu_rdata and host_rdata = 0;
//      an in-flight response is dropped.
//    Grants stay comb but are forced to 0 while rst=0.
//  - host_req dropped before its grant: legal. No access is made, and streak clears.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined:
//    adds outputs stat_cpu_gnt, stat_host_gnt and stat_conflict (32 bits each).
//    Each counter increments on cpu_gnt, host_gnt, or (cpu_req & host_req) respectively. Counters saturate at 32'hFFFF_FFFF and reset to 0.
//  Not defined: these ports and counters do not exist. Arbitration is identical either way.
// TESTING
//  1. CPU only: store addr 0x10 = 0xDEADBEEF, then load 0x10 -> cpu_stall=0 throughout; cpu_rvalid the cycle after the load grant with cpu_rdata=0xDEADBEEF.
//  2. Host only: write addr 0 = 0x1, read addr 0 -> host_gnt the same cycle as each req; host_ack +1 cycle; host_rdata=0x00000001.
//  3. Conflict, MAX_STREAK=4: cpu_req and host_req held high -> 4 cpu_gnt, then 1 host_gnt with cpu_stall=1 that cycle, then the pattern repeats.
//  4. Host req with cpu_req=0 in the same cycle as a prior CPU response -> cpu_rvalid and host_gnt coexist; the next cycle only host_ack is set, with correct data routing.
//  5. Reset asserted the cycle after a CPU load grant -> cpu_rvalid stays 0 and streak=0. After release, the first conflict grants CPU.
//  6. DMEM_ARB_STATS_EN, 10 conflict cycles at MAX_STREAK=4 -> stat_conflict=10, stat_cpu_gnt=8, stat_host_gnt=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Per-cycle arbiter sharing the single-port data RAM between the CPU load/store path and a host/loader port.
// Optional activity counters are compiled in when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_cpu_gnt,
    output logic [31:0]       stat_host_gnt,
    output logic [31:0]       stat_conflict
`endif
);

    localparam int STREAK_W = $clog2(MAX_STREAK + 1);

    logic [STREAK_W-1:0] streak;
    logic                streak_full;
    logic [1:0]          owner;

    assign streak_full = (streak == STREAK_W'(MAX_STREAK));

    // Grants are forced low during reset so the RAM is never touched while held.
    assign host_gnt  = rst & host_req & (~cpu_req | streak_full);
    assign cpu_gnt   = rst & cpu_req & ~host_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_en    = cpu_gnt | host_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    // Counts CPU wins while the host is waiting; a full streak hands the next conflict to the host.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (!host_req || host_gnt) begin
            streak <= '0;
        end else if (cpu_gnt && !streak_full) begin
            streak <= streak + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= 2'b00;
        end else begin
            owner <= {host_gnt, cpu_gnt};
        end
    end

    assign cpu_rvalid = owner[0];
    assign host_ack   = owner[1];
    assign cpu_rdata  = owner[0] ? mem_rdata : '0;
    assign host_rdata = owner[1] ? mem_rdata : '0;

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cpu_gnt  <= '0;
            stat_host_gnt <= '0;
            stat_conflict <= '0;
        end else begin
            if (cpu_gnt && stat_cpu_gnt != 32'hFFFF_FFFF) begin
                stat_cpu_gnt <= stat_cpu_gnt + 32'd1;
            end
            if (host_gnt && stat_host_gnt != 32'hFFFF_FFFF) begin
                stat_host_gnt <= stat_host_gnt + 32'd1;
            end
            if (cpu_req && host_req && stat_conflict != 32'hFFFF_FFFF) begin
                stat_conflict <= stat_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a reference model and a write-first RAM.
// Stats checks are compiled in when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 32;
    localparam int MAX_STREAK = 4;

    logic              clk, rst;
    logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              host_req, host_we, host_gnt, host_ack;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata, host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_cpu_gnt, stat_host_gnt, stat_conflict;
    longint      m_cpu_cnt, m_host_cnt, m_conf_cnt;
`endif

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STREAK(MAX_STREAK)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_gnt(stat_cpu_gnt), .stat_host_gnt(stat_host_gnt), .stat_conflict(stat_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first synchronous RAM, 1-cycle read latency.
    logic [DATA_W-1:0] ram [int];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[int'(mem_addr)] = mem_wdata;
                mem_rdata <= mem_wdata;
            end else begin
                mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : '0;
            end
        end
    end

    // Reference model: memory contents, host wait count, pending response.
    logic [DATA_W-1:0] ref_mem [int];
    int                wins;
    bit                pend_cpu, pend_host, last_host_gnt;
    logic [DATA_W-1:0] pend_data;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    endfunction

    // One clock: called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input bit rst_mid = 1'b0);
        bit                eh, ec;
        logic              ewe;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        #1;
        eh  = rst && host_req && (!cpu_req || wins >= MAX_STREAK);
        ec  = rst && cpu_req && !eh;
        ewe = eh ? host_we : (ec ? cpu_we : 1'b0);
        ea  = eh ? host_addr : (ec ? cpu_addr : '0);
        ed  = eh ? host_wdata : (ec ? cpu_wdata : '0);
        checks++; if (cpu_gnt !== ec) begin errors++; $display("FAIL cpu_gnt got %b exp %b t=%0t", cpu_gnt, ec, $time); end
        checks++; if (host_gnt !== eh) begin errors++; $display("FAIL host_gnt got %b exp %b t=%0t", host_gnt, eh, $time); end
        checks++; if (cpu_stall !== (cpu_req && !ec)) begin errors++; $display("FAIL cpu_stall got %b exp %b t=%0t", cpu_stall, cpu_req && !ec, $time); end
        checks++; if (mem_en !== (eh || ec)) begin errors++; $display("FAIL mem_en got %b exp %b t=%0t", mem_en, eh || ec, $time); end
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {ewe, ea, ed}) begin errors++; $display("FAIL mem_bus got we=%b a=%h d=%h exp we=%b a=%h d=%h t=%0t", mem_we, mem_addr, mem_wdata, ewe, ea, ed, $time); end
        checks++; if (cpu_rvalid !== pend_cpu || cpu_rdata !== (pend_cpu ? pend_data : '0)) begin errors++; $display("FAIL cpu_resp got v=%b d=%h exp v=%b d=%h t=%0t", cpu_rvalid, cpu_rdata, pend_cpu, pend_cpu ? pend_data : '0, $time); end
        checks++; if (host_ack !== pend_host || host_rdata !== (pend_host ? pend_data : '0)) begin errors++; $display("FAIL host_resp got a=%b d=%h exp a=%b d=%h t=%0t", host_ack, host_rdata, pend_host, pend_host ? pend_data : '0, $time); end
        pend_cpu  = ec;
        pend_host = eh;
        last_host_gnt = eh;
        if (eh || ec) begin
            pend_data = ewe ? ed : ref_rd(ea);
            if (ewe) ref_mem[int'(ea)] = ed;
        end
        if (rst && host_req && ec) wins++;
        else wins = 0;
`ifdef DMEM_ARB_STATS_EN
        if (!rst) begin
            m_cpu_cnt = 0; m_host_cnt = 0; m_conf_cnt = 0;
        end else begin
            if (ec && m_cpu_cnt < 64'hFFFF_FFFF) m_cpu_cnt++;
            if (eh && m_host_cnt < 64'hFFFF_FFFF) m_host_cnt++;
            if (cpu_req && host_req && m_conf_cnt < 64'hFFFF_FFFF) m_conf_cnt++;
        end
`endif
        @(posedge clk);
        if (rst_mid) begin
            #1;
            rst = 1'b0;
            pend_cpu = 1'b0; pend_host = 1'b0; wins = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        cpu_req = 1; host_req = 1;
        #2;
        checks++; if (cpu_gnt !== 1'b0 || host_gnt !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL reset_grants got c=%b h=%b en=%b exp 0", cpu_gnt, host_gnt, mem_en); end
        checks++; if (cpu_rvalid !== 1'b0 || host_ack !== 1'b0 || cpu_rdata !== '0 || host_rdata !== '0) begin errors++; $display("FAIL reset_resp got v=%b a=%b exp 0", cpu_rvalid, host_ack); end
        @(negedge clk);
        step();
        step();
        idle_inputs();
        rst = 1'b1;
        step();
    endtask

    task automatic test_cpu_only();
        idle_inputs();
        cpu_req = 1; cpu_we = 1; cpu_addr = 14'h10; cpu_wdata = 32'hDEADBEEF;
        step();
        cpu_we = 0; cpu_wdata = '0;
        step();
        idle_inputs();
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_load got v=%b d=%h exp v=1 d=deadbeef", cpu_rvalid, cpu_rdata); end
        step();
    endtask

    task automatic test_host_only();
        idle_inputs();
        host_req = 1; host_we = 1; host_addr = '0; host_wdata = 32'h1;
        step();
        host_we = 0; host_wdata = '0;
        step();
        idle_inputs();
        checks++; if (host_ack !== 1'b1 || host_rdata !== 32'h1) begin errors++; $display("FAIL host_read got a=%b d=%h exp a=1 d=00000001", host_ack, host_rdata); end
        step();
    endtask

    task automatic test_conflict();
        idle_inputs();
        step();
        for (int i = 0; i < 15; i++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = 14'($urandom_range(0, 15));
            host_req = 1; host_we = 0; host_addr = 14'h3;
            #1;
            checks++; if (host_gnt !== (i % 5 == 4) || cpu_stall !== (i % 5 == 4)) begin errors++; $display("FAIL conflict_pattern i=%0d got h=%b s=%b exp %b", i, host_gnt, cpu_stall, i % 5 == 4); end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_handoff();
        idle_inputs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h10;
        step();
        cpu_req = 0; host_req = 1; host_we = 0; host_addr = 14'h0;
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || host_gnt !== 1'b1) begin errors++; $display("FAIL handoff_overlap got v=%b g=%b exp 1 1", cpu_rvalid, host_gnt); end
        step();
        idle_inputs();
        checks++; if (cpu_rvalid !== 1'b0 || host_ack !== 1'b1 || host_rdata !== 32'h1) begin errors++; $display("FAIL handoff_ack got v=%b a=%b d=%h exp 0 1 00000001", cpu_rvalid, host_ack, host_rdata); end
        step();
    endtask

    task automatic test_reset_inflight();
        idle_inputs();
        cpu_req = 1; cpu_we = 0; cpu_addr = 14'h10;
        host_req = 1; host_addr = 14'h5;
        step(1'b1);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== '0 || u_dut.streak !== '0) begin errors++; $display("FAIL reset_inflight got v=%b d=%h streak=%0d exp 0", cpu_rvalid, cpu_rdata, u_dut.streak); end
        step();
        rst = 1'b1;
        #1;
        checks++; if (cpu_gnt !== 1'b1 || host_gnt !== 1'b0) begin errors++; $display("FAIL reset_first_conflict got c=%b h=%b exp 1 0", cpu_gnt, host_gnt); end
        step();
        idle_inputs();
        step();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        idle_inputs();
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cpu_req = 1; cpu_addr = 14'(i); host_req = 1; host_addr = 14'h7;
            step();
        end
        idle_inputs();
        checks++; if (stat_conflict !== 32'd10 || stat_cpu_gnt !== 32'd8 || stat_host_gnt !== 32'd2) begin errors++; $display("FAIL stats got conf=%0d cpu=%0d host=%0d exp 10 8 2", stat_conflict, stat_cpu_gnt, stat_host_gnt); end
        step();
    endtask
`endif

    task automatic test_random();
        idle_inputs();
        for (int i = 0; i < 600; i++) begin
            cpu_req   = ($urandom_range(0, 9) < 6);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 14'($urandom_range(0, 15));
            cpu_wdata = $urandom;
            if (!host_req || last_host_gnt) begin
                host_req   = ($urandom_range(0, 2) == 0);
                host_we    = 1'($urandom_range(0, 1));
                host_addr  = 14'($urandom_range(0, 15));
                host_wdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                host_req = 1'b0;
            end
            step();
        end
        idle_inputs();
        step();
`ifdef DMEM_ARB_STATS_EN
        checks++; if ({stat_cpu_gnt, stat_host_gnt, stat_conflict} !== {m_cpu_cnt[31:0], m_host_cnt[31:0], m_conf_cnt[31:0]}) begin errors++; $display("FAIL stats_random got %0d %0d %0d exp %0d %0d %0d", stat_cpu_gnt, stat_host_gnt, stat_conflict, m_cpu_cnt, m_host_cnt, m_conf_cnt); end
`endif
    endtask

    initial begin
        wins = 0; pend_cpu = 0; pend_host = 0; last_host_gnt = 0; pend_data = '0;
`ifdef DMEM_ARB_STATS_EN
        m_cpu_cnt = 0; m_host_cnt = 0; m_conf_cnt = 0;
`endif
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_cpu_only();
        test_host_only();
        test_conflict();
        test_handoff();
        test_reset_inflight();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end
endmodule
